// File: rtl/spec_hold_buffer_if.sv
// spec_hold_buffer_if
// Handshake bundle between decode (producer), the hold buffer and dispatch
// (consumer).
//   in_valid/in_ready/in_inst/in_pc      : decode -> buffer enqueue channel
//   out_valid/out_ready/out_inst/out_pc  : buffer -> dispatch release channel
// Modports:
//   slave  : the hold buffer side
//   master : the environment side (decode + dispatch)
interface spec_hold_buffer_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/spec_hold_buffer.sv
// spec_hold_buffer
// Holds decoded instructions between decode and dispatch while a single
// branch is unresolved. Entries accepted while branch_pending is high are
// tagged speculative and withheld; resolve releases them in order, kill
// drops them. Non-speculative entries drain as a normal FIFO.
//
// Ports:
//   clock          : single clock, posedge
//   reset          : synchronous, active-low
//   branch_pending : a branch is unresolved
//   kill           : pulse, drop speculative entries
//   resolve        : pulse, clear speculative tags
//   bus            : spec_hold_buffer_if.slave (enqueue + release channels)
//   squash         : registered pulse the cycle after kill
//   squash_count   : entries dropped by that kill (valid with squash)
//   stat_squashed  : saturating drop total, only with SPEC_HOLD_STATS_EN
//
// Build option: define SPEC_HOLD_STATS_EN to add the stat_squashed counter.
module spec_hold_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       branch_pending,
  input  logic                       kill,
  input  logic                       resolve,
  spec_hold_buffer_if.slave          bus,
  output logic                       squash,
  output logic [$clog2(DEPTH):0]     squash_count
`ifdef SPEC_HOLD_STATS_EN
  ,
  output logic [31:0]                stat_squashed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_spec_cnt;
  logic [DEPTH-1:0] r_spec;
  logic            r_squash;
  logic [CW-1:0]   r_squash_count;
  logic [31:0]     r_inst [DEPTH];
  logic [XLEN-1:0] r_pc   [DEPTH];

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_enq;
  logic            w_write;
  logic            w_deq;
  logic            w_enq_spec;
  logic [AW-1:0]   w_head_nxt;
  logic [AW-1:0]   w_tail_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_spec_cnt_nxt;
  logic [DEPTH-1:0] w_spec_nxt;

  // Release/accept status depends on registered state only.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0) && !r_spec[r_head];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = r_inst[r_head];
  assign bus.out_pc    = r_pc[r_head];
  assign squash        = r_squash;
  assign squash_count  = r_squash_count;

  assign w_enq      = bus.in_valid && w_in_ready;
  // An incoming entry on a kill cycle is dropped rather than stored.
  assign w_write    = w_enq && !kill;
  assign w_deq      = w_out_valid && bus.out_ready;
  assign w_enq_spec = branch_pending && !resolve && !kill;

  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_spec_cnt_nxt = r_spec_cnt;
    w_spec_nxt     = r_spec;

    if (w_deq) begin
      w_head_nxt  = r_head + AW'(1);
      w_count_nxt = w_count_nxt - CW'(1);
    end

    if (kill) begin
      // Speculative entries are the youngest suffix, so rolling tail back
      // by spec_cnt removes exactly them. spec_cnt == DEPTH wraps to tail.
      w_tail_nxt     = r_tail - r_spec_cnt[AW-1:0];
      w_count_nxt    = w_count_nxt - r_spec_cnt;
      w_spec_cnt_nxt = '0;
      w_spec_nxt     = '0;
    end else begin
      if (resolve) begin
        w_spec_cnt_nxt = '0;
        w_spec_nxt     = '0;
      end
      if (w_write) begin
        w_tail_nxt         = r_tail + AW'(1);
        w_count_nxt        = w_count_nxt + CW'(1);
        w_spec_nxt[r_tail] = w_enq_spec;
        if (w_enq_spec) begin
          w_spec_cnt_nxt = w_spec_cnt_nxt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_spec_cnt     <= '0;
      r_spec         <= '0;
      r_squash       <= 1'b0;
      r_squash_count <= '0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_spec_cnt <= w_spec_cnt_nxt;
      r_spec     <= w_spec_nxt;
      r_squash   <= kill;
      if (kill) begin
        // A speculative handshake on the kill cycle counts as dropped too.
        r_squash_count <= r_spec_cnt + CW'(w_enq && branch_pending);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count/spec.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_inst[r_tail] <= bus.in_inst;
      r_pc[r_tail]   <= bus.in_pc;
    end
  end

`ifdef SPEC_HOLD_STATS_EN
  logic [31:0] r_stat_squashed;

  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stat_squashed <= '0;
    end else if (r_squash) begin
      r_stat_squashed <= sat_add32(r_stat_squashed, r_squash_count);
    end
  end

  assign stat_squashed = r_stat_squashed;
`endif

endmodule

// File: doc/spec_hold_buffer.md
# spec_hold_buffer

Holds decoded instructions between decode and dispatch while a branch is unresolved. Instructions that enter while the branch resolution unit reports `branch_pending` are tagged speculative and are not released. On `resolve` they are released in order; on `kill` they are dropped. Non-speculative instructions drain normally, giving in-order, zero-speculation dispatch behind a single pending branch.

## Interface
- `DEPTH`, 4: entry count, power of two, ≥2.
- `XLEN`, 64: PC width.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; 0 at a posedge resets the block.
- `branch_pending` in 1: from branch resolution unit; 1 = a branch is unresolved.
- `kill` in 1: one-cycle pulse; the pending branch was taken, so drop speculative entries.
- `resolve` in 1: one-cycle pulse; the pending branch was not taken, so clear speculative tags.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: buffer accepts this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: instruction PC.
- `out_valid` out 1: head entry releasable.
- `out_ready` in 1: dispatch accepts head.
- `out_inst` out 32, `out_pc` out XLEN: head entry contents.
- `squash` out 1: registered pulse, one cycle after `kill`.
- `squash_count` out $clog2(DEPTH)+1: entries dropped by that kill; valid only with `squash`.
- `stat_squashed` out 32: present only with `SPEC_HOLD_STATS_EN`.

## Operation
- Circular FIFO: `head`, `tail` pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` of $clog2(DEPTH)+1 bits; per-entry `spec` bit.
- Enqueue on `in_valid && in_ready`. The entry's `spec` bit is `branch_pending && !resolve && !kill` sampled that cycle.
- Because only one branch is ever pending, speculative entries always form a contiguous youngest suffix. `spec_cnt` tracks its length.
- `in_ready = (count != DEPTH)`. No enqueue-when-full-with-dequeue bypass.
- `out_valid = (count != 0) && !spec[head]`. Dequeue on `out_valid && out_ready`.
- `resolve`: clear all `spec` bits; `spec_cnt` ← 0. The same-cycle incoming entry is non-speculative.
- `kill`:
  - `tail` ← `tail - spec_cnt`; `count` ← `count - spec_cnt`.
  - A same-cycle incoming entry is not written.
  - `squash_count` ← `spec_cnt` + (1 if an incoming handshake occurred with `branch_pending`=1).
  - `squash` ← 1 next cycle.
- Same-cycle dequeue with `kill`: allowed. The head is non-speculative, so it is unaffected.
- `kill` and `resolve` in the same cycle: `kill` wins.
- `kill`/`resolve` with `spec_cnt`=0 and no incoming speculative entry: no state change; `squash` still pulses with `squash_count`=0 on `kill`.
- Reset (`reset`=0 at posedge), including mid-operation: head=tail=count=spec_cnt=0, all `spec` cleared, `squash`=0, `squash_count`=0, `stat_squashed`=0. Combinationally this gives `out_valid`=0 and `in_ready`=1.

## Timing
- Enqueue-to-release latency is 1 cycle minimum for a non-speculative entry: accepted at edge N, `out_valid` at N+1.
- A speculative entry becomes releasable in the cycle after the `resolve` edge, if it is at head.
- `squash` is high exactly one cycle, in the cycle after the `kill` edge.
- `in_ready` rises the cycle after a `kill` that frees space.
- Outputs `out_*` and `in_ready` are combinational from registered state only. There is no input-to-output combinational path.

## Configuration
- `SPEC_HOLD_STATS_EN` defined:
  - Adds port `stat_squashed`, a 32-bit saturating total of entries dropped, incremented by `squash_count` on each `squash`.
  - It holds at 32'hFFFF_FFFF once reached.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, then enqueue A (pc 0x100), B (0x104) with `branch_pending`=0 and `out_ready`=1 → A out at cycle 1, B at cycle 2, `out_valid`=0 after.
- Enqueue branch at 0x200 with pending=0, then C (0x204) and D (0x208) with pending=1, then pulse `kill` → branch released; then `squash`=1 with `squash_count`=2; C and D never appear; count=0.
- Same sequence with `resolve` instead of `kill` → 0x200, 0x204, 0x208 released in order; `squash` stays 0.
- Fill 4 entries with `out_ready`=0 → `in_ready`=0; `in_valid` held with 0x300 is not accepted. Assert `out_ready`=1 → `in_ready`=1 next cycle; 0x300 accepted.
- `kill` in the same cycle as a speculative enqueue (pending=1) with 1 existing speculative entry → `squash_count`=2; incoming not stored.
- Drive `reset`=0 for one edge with 3 entries, 2 speculative → `out_valid`=0, `in_ready`=1, `squash`=0 next cycle. With `SPEC_HOLD_STATS_EN`, `stat_squashed`=0 after reset and 2 after the kill scenario.
